mgc_shift_pipe: RTL

- Parametrised, pipelined barrel shifter: successor to the combinational left-shift operator in the Catapult operator library.
- Adds right shift (arithmetic or logical), optional signed shift amount (negative amount reverses direction), configurable pipeline depth, and valid/ready flow control.
- Sits between Catapult-generated datapath stages that need a high-fmax shifter with backpressure.

---
 rtl/mgc_shift_pipe_if.sv | 27 ++
 rtl/mgc_shift_pipe.sv | 119 +++++++++++
 2 files changed

// File: rtl/mgc_shift_pipe_if.sv
// Valid/ready bus for the pipelined barrel shifter: operand, shift control
// on the input side and the shifted result on the output side.
interface mgc_shift_pipe_if #(
  parameter int width_a = 8,
  parameter int width_s = 4,
  parameter int width_z = 12
);
  logic               in_vld;
  logic               in_rdy;
  logic [width_a-1:0] a;
  logic [width_s-1:0] s;
  logic               dir;
  logic               s_signed;
  logic               out_vld;
  logic               out_rdy;
  logic [width_z-1:0] z;

  modport master (
    output in_vld, a, s, dir, s_signed, out_rdy,
    input  in_rdy, out_vld, z
  );

  modport slave (
    input  in_vld, a, s, dir, s_signed, out_rdy,
    output in_rdy, out_vld, z
  );
endinterface

// File: rtl/mgc_shift_pipe.sv
// Pipelined barrel shifter with elastic valid/ready stages. The log2 mux
// levels of the shift amount are distributed over `stages` register stages.
module mgc_shift_pipe #(
  parameter int width_a = 8,
  parameter bit signd_a = 1'b1,
  parameter int width_s = 4,
  parameter int width_z = 12,
  parameter int stages  = 2
) (
  input  logic            clk,
  input  logic            rst,
  mgc_shift_pipe_if.slave bus
);
  // Wide enough that neither direction ever pulls unwanted bits into the
  // result window, so a plain logical shift of the pre-filled value suffices.
  localparam int ext_w         = ((width_a + 1 > width_z) ? width_a + 1 : width_z) + (1 << width_s);
  localparam int lvl_per_stage = (width_s + stages - 1) / stages;

  typedef logic [ext_w-1:0]   ext_t;
  typedef logic [width_s-1:0] amt_t;

  function automatic ext_t shift_levels(ext_t din, amt_t k, logic right, int lo, int hi);
    ext_t v;
    v = din;
    for (int b = 0; b < width_s; b++) begin
      if (b >= lo && b < hi && k[b]) begin
        v = right ? (v >> (1 << b)) : (v << (1 << b));
      end
    end
    return v;
  endfunction

  logic            neg_s;
  logic            fill_in;
  logic            right_in;
  amt_t            k_in;
  ext_t            ext_in;

  logic [stages-1:0] v_q;
  logic [stages-1:0] v_d;
  logic [stages:0]   load;
  logic [stages:0]   feed_v;

  always_comb begin
    neg_s    = bus.s_signed & bus.s[width_s-1];
    k_in     = neg_s ? (~bus.s + amt_t'(1)) : bus.s;
    right_in = bus.dir ^ neg_s;
    fill_in  = signd_a ? bus.a[width_a-1] : 1'b0;
    ext_in   = {{(ext_w - width_a){fill_in}}, bus.a};
  end

  // load[j]: stage j can take new content (empty, or emptying this cycle).
  always_comb begin
    load         = '0;
    v_d          = v_q;
    feed_v       = {v_q, bus.in_vld};
    load[stages] = bus.out_rdy;
    for (int j = stages - 1; j >= 0; j--) begin
      load[j] = ~v_q[j] | load[j+1];
      v_d[j]  = load[j] ? feed_v[j] : v_q[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar g = 0; g < stages; g++) begin : g_stage
    localparam int lo = g * lvl_per_stage;
    localparam int hi = (g + 1) * lvl_per_stage;

    ext_t data_q;
    ext_t data_d;
    amt_t k_q;
    logic right_q;
    ext_t src_data;
    amt_t src_k;
    logic src_right;

    if (g == 0) begin : g_head
      assign src_data  = ext_in;
      assign src_k     = k_in;
      assign src_right = right_in;
    end else begin : g_body
      assign src_data  = g_stage[g-1].data_q;
      assign src_k     = g_stage[g-1].k_q;
      assign src_right = g_stage[g-1].right_q;
    end

    always_comb begin
      data_d = shift_levels(src_data, src_k, src_right, lo, hi);
    end

    // Data only moves with a valid item so z holds its last value on bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        k_q     <= '0;
        right_q <= 1'b0;
      end else if (load[g] & feed_v[g]) begin
        data_q  <= data_d;
        k_q     <= src_k;
        right_q <= src_right;
      end
    end
  end

  logic unused_tail;
  assign unused_tail = ^{g_stage[stages-1].k_q, g_stage[stages-1].right_q,
                         g_stage[stages-1].data_q[ext_w-1:width_z]};

  assign bus.in_rdy  = ~rst & load[0];
  assign bus.out_vld = ~rst & v_q[stages-1];
  assign bus.z       = rst ? '0 : g_stage[stages-1].data_q[width_z-1:0];
endmodule
